// File: rtl/fft_out_serializer.sv
// Serializes 8-bin complex FFT frames into a 32-byte stream (re hi, re lo, im hi, im lo per bin).
// Two frame slots: the active frame is streamed; one more frame may wait in the pending slot.
module fft_out_serializer #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [127:0]      y_r,
  input  logic [127:0]      y_i,
  output logic              frame_ready,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_first,
  output logic              dout_last,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [255:0]        r_active;
  logic [255:0]        r_pending;
  logic                r_pend_full;
  logic [4:0]          r_idx;
  logic [DROP_W-1:0]   r_drop;

  logic [255:0]        w_frame;
  logic [7:0]          w_bytes [32];
  logic                w_accept;
  logic                w_hs;
  logic                w_end;

  // Frame layout: byte b of the stream lives at w_frame[8b+7:8b].
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pack
      assign w_frame[32*gi      +: 8] = y_r[16*gi + 8 +: 8];
      assign w_frame[32*gi + 8  +: 8] = y_r[16*gi     +: 8];
      assign w_frame[32*gi + 16 +: 8] = y_i[16*gi + 8 +: 8];
      assign w_frame[32*gi + 24 +: 8] = y_i[16*gi     +: 8];
    end
    for (gi = 0; gi < 32; gi++) begin : g_bytes
      assign w_bytes[gi] = r_active[8*gi +: 8];
    end
  endgenerate

  assign w_accept = frame_valid & ~r_pend_full;
  assign w_hs     = (r_state == SEND) & dout_ready;
  assign w_end    = w_hs & (r_idx == 5'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = SEND;
      SEND: if (w_end && !r_pend_full && !w_accept) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_idx       <= 5'd0;
      r_drop      <= '0;
    end else begin
      // The index wraps 31 -> 0 on the final handshake, which also restarts the next frame.
      if (w_hs) begin
        r_idx <= r_idx + 5'd1;
      end
      if (r_state == IDLE) begin
        if (w_accept) r_active <= w_frame;
      end else if (w_end) begin
        if (r_pend_full) begin
          r_active    <= r_pending;
          r_pending   <= '0;
          r_pend_full <= 1'b0;
        end else if (w_accept) begin
          r_active <= w_frame;
        end
      end else if (w_accept) begin
        r_pending   <= w_frame;
        r_pend_full <= 1'b1;
      end
      if (frame_valid && r_pend_full && !(&r_drop)) begin
        r_drop <= r_drop + {{(DROP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign frame_ready = ~r_pend_full;
  assign dout_valid  = (r_state == SEND);
  assign dout        = dout_valid ? w_bytes[r_idx] : 8'h00;
  assign dout_first  = dout_valid & (r_idx == 5'd0);
  assign dout_last   = dout_valid & (r_idx == 5'd31);
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench: a byte-count model predicts accepted frames and bytes; a negedge monitor checks.
module tb_fft_out_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         frame_valid = 1'b0;
  logic [127:0] y_r = '0;
  logic [127:0] y_i = '0;
  logic         dout_ready = 1'b0;

  logic         frame_ready, dout_valid, dout_first, dout_last;
  logic [7:0]   dout;
  logic [7:0]   drop_cnt;
  logic         s_frame_ready, s_dout_valid, s_dout_first, s_dout_last;
  logic [7:0]   s_dout;
  logic [1:0]   s_drop_cnt;

  always #5 clk = ~clk;

  fft_out_serializer #(.DROP_W(8)) u_dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .y_r(y_r), .y_i(y_i),
    .frame_ready(frame_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_first(dout_first), .dout_last(dout_last),
    .drop_cnt(drop_cnt)
  );

  fft_out_serializer #(.DROP_W(2)) u_sat (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .y_r(y_r), .y_i(y_i),
    .frame_ready(s_frame_ready), .dout(s_dout), .dout_valid(s_dout_valid),
    .dout_ready(dout_ready), .dout_first(s_dout_first), .dout_last(s_dout_last),
    .drop_cnt(s_drop_cnt)
  );

  typedef struct {
    logic [7:0] b;
    logic       f;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   rem = 0;
  int   drops = 0;
  bit   started = 0;
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;
  int   pat = 0;
  int   frames_done = 0;
  int   m_held;
  bit   m_acc;
  int   mon_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rem = bytes still owed; a frame occupies a slot until its last byte leaves.
  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      rem     = 0;
      drops   = 0;
      exp_q.delete();
    end else if (started) begin
      m_held = (rem + 31) / 32;
      m_acc  = frame_valid && (m_held < 2);
      if (frame_valid && !m_acc && drops < 255) drops++;
      if (rem > 0 && dout_ready) rem--;
      if (m_acc) begin
        rem += 32;
        for (int k = 0; k < 8; k++) begin
          logic [15:0] re, im;
          exp_t e;
          re = 16'(y_r >> (16 * k));
          im = 16'(y_i >> (16 * k));
          e.f = 1'b0; e.l = 1'b0;
          e.b = re[15:8]; e.f = (k == 0); exp_q.push_back(e); e.f = 1'b0;
          e.b = re[7:0];  exp_q.push_back(e);
          e.b = im[15:8]; exp_q.push_back(e);
          e.b = im[7:0];  e.l = (k == 7); exp_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      mon_held = (rem + 31) / 32;
      check("dout_valid", {31'd0, dout_valid}, {31'd0, rem > 0});
      check("frame_ready", {31'd0, frame_ready}, {31'd0, mon_held < 2});
      check("drop_cnt", {24'd0, drop_cnt}, drops);
      check("drop_cnt_sat", {30'd0, s_drop_cnt}, (drops > 3) ? 3 : drops);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL byte: got %0h with nothing expected at %0t", dout, $time);
        end else begin
          check("byte", {22'd0, dout, dout_first, dout_last},
                {22'd0, exp_q[0].b, exp_q[0].f, exp_q[0].l});
          if (dout_ready) begin
            if (exp_q[0].l) begin
              frames_done++;
              $display("frame %0d streamed, completed at %0t", frames_done, $time);
            end
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_out", {21'd0, dout, dout_first, dout_last}, 32'd0);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: begin dout_ready = (pat == 0) || (pat == 3); pat = (pat + 1) % 4; end
      2: dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b0;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] re, input logic [127:0] im);
    y_r = re;
    y_i = im;
    frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
  endtask

  task automatic send_directed();
    logic [127:0] re, im;
    for (int k = 0; k < 8; k++) begin
      re[16*k +: 16] = 16'h1000 + 16'(k);
      im[16*k +: 16] = 16'hF000 + 16'(k);
    end
    send(re, im);
  endtask

  task automatic send_random();
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) cyc();
    check("rst_ready", {31'd0, frame_ready}, 32'd1);
    reset = 1'b0;

    ready_mode = 0;
    send_directed();
    repeat (40) cyc();

    ready_mode = 1;
    send_directed();
    repeat (140) cyc();

    ready_mode = 0;
    send_random();
    cyc();
    send_random();
    repeat (75) cyc();

    ready_mode = 3;
    repeat (3) send_random();
    repeat (4) cyc();
    check("ovf_drop", {24'd0, drop_cnt}, 32'd1);
    ready_mode = 0;
    repeat (75) cyc();

    ready_mode = 3;
    repeat (7) send_random();
    repeat (2) cyc();
    check("sat_hold", {30'd0, s_drop_cnt}, 32'd3);
    ready_mode = 0;
    repeat (75) cyc();

    send_random();
    send_random();
    repeat (9) cyc();
    reset = 1'b1;
    frame_valid = 1'b1;
    cyc();
    reset = 1'b0;
    frame_valid = 1'b0;
    check("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, frame_ready}, 32'd1);
    check("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
    send_directed();
    repeat (40) cyc();

    ready_mode = 2;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) send_random();
      else cyc();
    end
    reset = 1'b0;
    ready_mode = 0;
    repeat (90) cyc();

    check("drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
